// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the 16-bit CR-CPU core.
// Fetches each instruction from the PC's ROM into an internal instruction
// register, then sequences the PC, data RAM and register-file strobes.
// Every strobe is registered and is high for exactly one cycle per instruction.
//
// Optional feature macro: SEQ_HALT_ON_UNDEF_EN
//   defined   - an undefined opcode in DECODE parks the FSM in HALT until reset
//   undefined - undefined opcodes retire as 3-cycle NOPs; o_halted is tied 0
module core_sequencer #(
  parameter int INST_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_run,
  input  logic                       i_step,
  input  logic [15:0]                i_inst,
  input  logic [15:0]                i_alu_data,
  input  logic [15:0]                i_ram_data,
  output logic                       o_pc_inc,
  output logic                       o_pc_load,
  output logic [INST_ADDR_WIDTH-1:0] o_pc_addr,
  output logic [15:0]                o_ir,
  output logic                       o_ram_load,
  output logic [DATA_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [3:0]                 o_reg_load,
  output logic [1:0]                 o_wb_sel,
  output logic                       o_step_ack,
  output logic                       o_halted,
  output logic [CNT_WIDTH-1:0]       o_retired
);

  // Opcodes held in ir[15:12]; 10..15 are undefined.
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SHIFT = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_STORE = 4'd6;
  localparam logic [3:0] OP_MOVE  = 4'd7;
  localparam logic [3:0] OP_JUMP  = 4'd8;
  localparam logic [3:0] OP_LOADC = 4'd9;

  // Write-back mux selections.
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_RAM   = 2'b01;
  localparam logic [1:0] WB_CONST = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_nx;

  // Fields of the word arriving from ROM (valid during DECODE).
  logic [3:0] dec_op;
  logic [1:0] dec_hi;
  logic [1:0] dec_lo;
  logic [7:0] dec_k;
  assign dec_op = i_inst[15:12];
  assign dec_hi = i_inst[11:10];
  assign dec_lo = i_inst[9:8];
  assign dec_k  = i_inst[7:0];

  // Fields of the latched instruction (valid from EXEC onwards).
  logic [3:0] ir_op;
  logic [1:0] ir_hi;
  assign ir_op = o_ir[15:12];
  assign ir_hi = o_ir[11:10];

  // The sequencer only steers the data path; the data buses themselves are
  // consumed by the write-back mux outside this block.
  logic unused_data;
  assign unused_data = ^{i_alu_data, i_ram_data};

  // Retire happens in EXEC for everything except LOAD, which retires in WB.
  logic retire;
  assign retire = ((state == S_EXEC) && (ir_op != OP_LOAD)) || (state == S_WB);

  // A stepped instruction acknowledges in its retire cycle.
  assign o_step_ack = retire && !i_run;

`ifdef SEQ_HALT_ON_UNDEF_EN
  logic dec_undef;
  assign dec_undef = (dec_op > OP_LOADC);
  assign o_halted  = (state == S_HALT);
`else
  assign o_halted  = 1'b0;
`endif

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (i_run || i_step) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        state_nx = S_EXEC;
`ifdef SEQ_HALT_ON_UNDEF_EN
        if (dec_undef) state_nx = S_HALT;
`endif
      end
      S_EXEC: begin
        if (ir_op == OP_LOAD) state_nx = S_MEM;
        else                  state_nx = i_run ? S_FETCH : S_IDLE;
      end
      S_MEM:    state_nx = S_WB;
      S_WB:     state_nx = i_run ? S_FETCH : S_IDLE;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered strobes, decided one cycle ahead so they
  // come straight out of flops in EXEC or WB.
  logic                       pc_inc_nx;
  logic                       pc_load_nx;
  logic [INST_ADDR_WIDTH-1:0] pc_addr_nx;
  logic                       ram_load_nx;
  logic [DATA_ADDR_WIDTH-1:0] ram_addr_nx;
  logic [3:0]                 reg_load_nx;
  logic [1:0]                 wb_sel_nx;

  // Strobe decode: DECODE->EXEC uses the ROM word, MEM->WB uses the IR.
  always_comb begin
    pc_inc_nx   = 1'b0;
    pc_load_nx  = 1'b0;
    pc_addr_nx  = o_pc_addr;
    ram_load_nx = 1'b0;
    ram_addr_nx = o_ram_addr;
    reg_load_nx = 4'b0000;
    wb_sel_nx   = WB_ALU;
    if ((state == S_DECODE) && (state_nx == S_EXEC)) begin
      case (dec_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHIFT: begin
          reg_load_nx = onehot(dec_hi);
          pc_inc_nx   = 1'b1;
        end
        OP_MOVE: begin
          reg_load_nx = onehot(dec_lo);
          pc_inc_nx   = 1'b1;
        end
        OP_LOADC: begin
          reg_load_nx = onehot(dec_hi);
          wb_sel_nx   = WB_CONST;
          pc_inc_nx   = 1'b1;
        end
        OP_LOAD: begin
          // Address goes out in EXEC; the register write waits for WB.
          ram_addr_nx = DATA_ADDR_WIDTH'(dec_k);
        end
        OP_STORE: begin
          ram_addr_nx = DATA_ADDR_WIDTH'(dec_k);
          ram_load_nx = 1'b1;
          pc_inc_nx   = 1'b1;
        end
        OP_JUMP: begin
          pc_load_nx = 1'b1;
          pc_addr_nx = INST_ADDR_WIDTH'(dec_k);
        end
        default: begin
          // Undefined opcode retiring as a NOP.
          pc_inc_nx = 1'b1;
        end
      endcase
    end else if (state == S_MEM) begin
      reg_load_nx = onehot(ir_hi);
      wb_sel_nx   = WB_RAM;
      pc_inc_nx   = 1'b1;
    end
  end

  // Strobe and address registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc_inc   <= 1'b0;
      o_pc_load  <= 1'b0;
      o_pc_addr  <= '0;
      o_ram_load <= 1'b0;
      o_ram_addr <= '0;
      o_reg_load <= 4'b0000;
      o_wb_sel   <= WB_ALU;
    end else begin
      o_pc_inc   <= pc_inc_nx;
      o_pc_load  <= pc_load_nx;
      o_pc_addr  <= pc_addr_nx;
      o_ram_load <= ram_load_nx;
      o_ram_addr <= ram_addr_nx;
      o_reg_load <= reg_load_nx;
      o_wb_sel   <= wb_sel_nx;
    end
  end

  // Instruction register: captures the ROM word at the end of DECODE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               o_ir <= 16'h0000;
    else if (state == S_DECODE) o_ir <= i_inst;
  end

  // Retired-instruction counter; wraps naturally to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_retired <= '0;
    else if (retire) o_retired <= o_retired + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed bench for core_sequencer. Models the PC and a
// synchronous ROM around the sequencer; a second instance with a 2-bit
// retire counter exposes the counter wrap. Honours SEQ_HALT_ON_UNDEF_EN.
module tb_core_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_run = 1'b0;
  logic        i_step = 1'b0;
  logic [15:0] i_inst;
  logic [15:0] i_alu_data;
  logic [15:0] i_ram_data;

  logic        o_pc_inc, o_pc_load, o_ram_load, o_step_ack, o_halted;
  logic [7:0]  o_pc_addr, o_ram_addr;
  logic [15:0] o_ir, o_retired;
  logic [3:0]  o_reg_load;
  logic [1:0]  o_wb_sel;

  logic        unused_w_pc_inc, unused_w_pc_load, unused_w_ram_load;
  logic        unused_w_step_ack, unused_w_halted;
  logic [7:0]  unused_w_pc_addr, unused_w_ram_addr;
  logic [15:0] unused_w_ir;
  logic [3:0]  unused_w_reg_load;
  logic [1:0]  unused_w_wb_sel;
  logic [1:0]  w_retired;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;

  logic [15:0] rom [0:255];
  logic [7:0]  pc;

  assign i_alu_data = 16'h1234;
  assign i_ram_data = 16'hBEEF;

  always #5 i_clk = ~i_clk;

  core_sequencer #(.INST_ADDR_WIDTH(8), .DATA_ADDR_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_step(i_step),
    .i_inst(i_inst), .i_alu_data(i_alu_data), .i_ram_data(i_ram_data),
    .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load), .o_pc_addr(o_pc_addr),
    .o_ir(o_ir), .o_ram_load(o_ram_load), .o_ram_addr(o_ram_addr),
    .o_reg_load(o_reg_load), .o_wb_sel(o_wb_sel), .o_step_ack(o_step_ack),
    .o_halted(o_halted), .o_retired(o_retired)
  );

  core_sequencer #(.INST_ADDR_WIDTH(8), .DATA_ADDR_WIDTH(8), .CNT_WIDTH(2)) u_dut_wrap (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_step(i_step),
    .i_inst(i_inst), .i_alu_data(i_alu_data), .i_ram_data(i_ram_data),
    .o_pc_inc(unused_w_pc_inc), .o_pc_load(unused_w_pc_load), .o_pc_addr(unused_w_pc_addr),
    .o_ir(unused_w_ir), .o_ram_load(unused_w_ram_load), .o_ram_addr(unused_w_ram_addr),
    .o_reg_load(unused_w_reg_load), .o_wb_sel(unused_w_wb_sel), .o_step_ack(unused_w_step_ack),
    .o_halted(unused_w_halted), .o_retired(w_retired)
  );

  // Program counter and synchronous ROM (1-cycle read latency).
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc     <= 8'd0;
      i_inst <= 16'h0000;
    end else begin
      if (o_pc_load)     pc <= o_pc_addr;
      else if (o_pc_inc) pc <= pc + 8'd1;
      i_inst <= rom[pc];
    end
  end

  // Count step acknowledges where the DUT samples them.
  always @(posedge i_clk) begin
    if (i_rst_n && o_step_ack) ack_cnt <= ack_cnt + 1;
  end

  logic [6:0] strb;
  assign strb = {o_reg_load, o_pc_inc, o_pc_load, o_ram_load};

  function automatic logic [6:0] exp_s(input logic [3:0] r, input logic inc,
                                       input logic ld, input logic rl);
    return {r, inc, ld, rl};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // One single-step from IDLE of a LOADC instruction.
  task automatic step_one(input string tag, input logic [3:0] reg_oh, input int ret);
    i_step = 1'b1;
    tick();                         // FETCH
    i_step = 1'b0;
    tick();                         // DECODE
    tick();                         // EXEC
    check({tag, "_exec"}, strb, exp_s(reg_oh, 1'b1, 1'b0, 1'b0));
    check({tag, "_wbsel"}, o_wb_sel, 2'b10);
    check({tag, "_ack"}, o_step_ack, 1'b1);
    tick();                         // IDLE
    check({tag, "_ack_low"}, o_step_ack, 1'b0);
    check({tag, "_retired"}, o_retired, ret);
    repeat (4) tick();
    check({tag, "_idle"}, {strb, o_retired}, {7'd0, 16'(ret)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h9C2A;  // LOADC r3,0x2A
    rom[1]  = 16'h5410;  // LOAD  r1,[0x10]
    rom[2]  = 16'h6411;  // STORE r1,[0x11]
    rom[3]  = 16'h8005;  // JUMP  0x05
    rom[5]  = 16'h7E00;  // MOVE  dest lo=r2
    rom[6]  = 16'h0100;  // ADD   r0
    rom[7]  = 16'hF000;  // undefined
    rom[8]  = 16'h1400;  // SUB   r1
    rom[9]  = 16'h9001;  // LOADC r0
    rom[10] = 16'h9402;  // LOADC r1
    rom[11] = 16'h0C00;  // ADD   r3
    rom[12] = 16'h0800;  // ADD   r2
    rom[13] = 16'h5820;  // LOAD  r2,[0x20]

    i_rst_n = 1'b0;
    i_run   = 1'b1;
    repeat (3) tick();
    check("rst_ir", o_ir, 16'h0000);
    check("rst_retired", o_retired, 16'd0);
    check("rst_strobes", strb, 7'd0);
    check("rst_addrs", {o_pc_addr, o_ram_addr, o_wb_sel}, 18'd0);
    check("rst_halted", o_halted, 1'b0);

    // Test 1: LOADC r3,0x2A, 3 cycles from FETCH entry.
    i_rst_n = 1'b1;
    tick();
    check("t1_fetch", strb, 7'd0);
    tick();
    check("t1_decode_ir", o_ir, 16'h0000);
    tick();
    check("t1_ir", o_ir, 16'h9C2A);
    check("t1_exec", strb, exp_s(4'b1000, 1'b1, 1'b0, 1'b0));
    check("t1_wbsel", o_wb_sel, 2'b10);
    check("t1_retired_pre", o_retired, 16'd0);
    tick();
    check("t1_retired", o_retired, 16'd1);
    check("t1_after", strb, 7'd0);

    // Test 2: LOAD r1,[0x10] (5 cycles) then STORE r1,[0x11] (3 cycles).
    tick(); tick();
    check("t2_ld_exec", strb, 7'd0);
    check("t2_ld_addr", o_ram_addr, 8'h10);
    check("t2_ld_ir", o_ir, 16'h5410);
    tick();
    check("t2_ld_mem", strb, 7'd0);
    tick();
    check("t2_ld_wb", strb, exp_s(4'b0010, 1'b1, 1'b0, 1'b0));
    check("t2_ld_wbsel", o_wb_sel, 2'b01);
    check("t2_ld_retired_pre", o_retired, 16'd1);
    tick();
    check("t2_ld_retired", o_retired, 16'd2);
    tick(); tick();
    check("t2_st_exec", strb, exp_s(4'b0000, 1'b1, 1'b0, 1'b1));
    check("t2_st_addr", o_ram_addr, 8'h11);
    tick();
    check("t2_st_after", {strb, o_ram_addr, o_retired}, {7'd0, 8'h11, 16'd3});

    // Test 3: JUMP 0x05, next FETCH immediately, lands on MOVE at ROM[5].
    tick(); tick();
    check("t3_jmp", strb, exp_s(4'b0000, 1'b0, 1'b1, 1'b0));
    check("t3_jmp_addr", o_pc_addr, 8'h05);
    tick();
    check("t3_after", {strb, o_retired}, {7'd0, 16'd4});
    tick(); tick();
    check("t3_move", strb, exp_s(4'b0100, 1'b1, 1'b0, 1'b0));
    check("t3_move_wbsel", o_wb_sel, 2'b00);
    repeat (3) tick();
    check("add_exec", strb, exp_s(4'b0001, 1'b1, 1'b0, 1'b0));
    repeat (3) tick();

`ifdef SEQ_HALT_ON_UNDEF_EN
    // Test 6 (halt build): undefined opcode halts with strobes quiet.
    check("t6_halted", o_halted, 1'b1);
    check("t6_strb", strb, 7'd0);
    check("t6_retired", o_retired, 16'd6);
    check("t6_wrap", w_retired, 2'd2);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("t6_hold", {o_halted, strb, o_retired}, {1'b1, 7'd0, 16'd6});
    end
    #2 i_rst_n = 1'b0;
    #1;
    check("t5_rst_halted", o_halted, 1'b0);
    check("t5_rst_async", {strb, o_retired, o_ir, o_ram_addr}, 47'd0);
`else
    // Test 6 (default build): undefined opcode is a NOP.
    check("t6_nop", strb, exp_s(4'b0000, 1'b1, 1'b0, 1'b0));
    check("t6_nop_ir", o_ir, 16'hF000);
    check("t6_halted", o_halted, 1'b0);
    tick();
    check("t6_retired", o_retired, 16'd7);
    check("t6_wrap_pre", w_retired, 2'd3);

    // i_run drops mid-instruction: SUB completes, then IDLE.
    i_run = 1'b0;
    tick(); tick();
    check("run_drop_exec", strb, exp_s(4'b0010, 1'b1, 1'b0, 1'b0));
    check("run_drop_ack", o_step_ack, 1'b1);
    tick();
    check("run_drop_retired", o_retired, 16'd8);
    check("cnt_wrap", w_retired, 2'd0);
    check("run_drop_idle", {strb, o_step_ack}, 8'd0);
    repeat (4) tick();
    check("idle_hold", {strb, o_retired}, {7'd0, 16'd8});

    // Test 4: two separate step pulses, IDLE between them.
    step_one("t4_step1", 4'b0001, 9);
    step_one("t4_step2", 4'b0010, 10);

    // i_step held high: one instruction per IDLE visit.
    i_step = 1'b1;
    tick(); tick(); tick();
    check("hold_exec1", strb, exp_s(4'b1000, 1'b1, 1'b0, 1'b0));
    tick();
    check("hold_idle", {strb, o_step_ack}, 8'd0);
    tick(); tick(); tick();
    check("hold_exec2", strb, exp_s(4'b0100, 1'b1, 1'b0, 1'b0));
    check("hold_ack2", o_step_ack, 1'b1);
    i_step = 1'b0;
    repeat (4) tick();
    check("hold_done", {strb, o_retired}, {7'd0, 16'd12});
    check("ack_count", ack_cnt, 5);

    // Test 5: reset during MEM of LOAD r2,[0x20].
    i_run = 1'b1;
    tick(); tick(); tick();
    check("t5_ld_addr", o_ram_addr, 8'h20);
    tick();
    check("t5_mem", strb, 7'd0);
    #2 i_rst_n = 1'b0;
    #1;
    check("t5_rst_async", {strb, o_retired, o_ir, o_ram_addr}, 47'd0);
`endif
    tick();
    check("t5_rst_hold", {strb, o_retired, o_ir, o_step_ack}, 40'd0);

    // After release the fetch restarts from address 0.
    i_rst_n = 1'b1;
    tick(); tick(); tick();
    check("t5_restart_ir", o_ir, 16'h9C2A);
    check("t5_restart", strb, exp_s(4'b1000, 1'b1, 1'b0, 1'b0));
    tick();
    check("t5_restart_retired", o_retired, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
